wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-cycle wide-operand adder controller that sits directly upstream and downstream of the 20-bit prefix adder.
- It slices NUM_WORDS*WORD_W-bit operands into WORD_W-bit words and feeds the adder one word per cycle, least-significant word first.
- It chains the adder's carry-out into the next word's carry-in through a register, collects the sum words, and presents the full result on a valid/ready output.
- The prefix adder stays purely combinational and is instantiated beside this block. This block owns all sequencing.

Parameters:
- WORD_W, 20, width of one adder slice; must match the attached adder.
- NUM_WORDS, 4, number of slices per operation; must be at least 2.
- IDX_W, 2, width of the word index; at least clog2(NUM_WORDS).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand.
- in_a  input  WORD_W*NUM_WORDS  operand A.
- in_b  input  WORD_W*NUM_WORDS  operand B.
- in_cin  input  1  carry-in to the least-significant word.
- add_a  output  WORD_W  current A word to the adder.
- add_b  output  WORD_W  current B word to the adder.
- add_cin  output  1  current carry to the adder.
- add_sum  input  WORD_W  adder sum, same cycle (combinational).
- add_cout  input  1  adder carry-out, same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WORD_W*NUM_WORDS  full-width sum.
- out_cout  output  1  final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state goes to IDLE; idx=0; carry register=0.
  - operand registers and out_sum cleared to 0; out_cout=0; out_valid=0.
  - Reset has priority over every other event, including mid-RUN and DONE; any in-flight operation is discarded with no output.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - add_a, add_b and add_cin are driven to 0.
  - On in_valid&in_ready: latch in_a, in_b; carry register <= in_cin; idx <= 0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Adder drive is combinational from registers: add_a = A[idx*WORD_W +: WORD_W], add_b likewise from B, add_cin = carry register.
  - Each cycle: out_sum word idx <= add_sum; carry register <= add_cout.
  - If idx==NUM_WORDS-1: out_cout <= add_cout and go to DONE. Otherwise idx <= idx+1.
  - Exactly NUM_WORDS RUN cycles; no early termination.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - out_sum and out_cout are held stable while out_ready=0, for any number of cycles.
  - On out_valid&out_ready: go to IDLE and clear out_valid. out_sum and out_cout keep their last values.
- Latency and throughput:
  - Accept at edge T; out_valid is high in the cycle after edge T+NUM_WORDS.
  - Minimum initiation interval is NUM_WORDS+2 cycles. in_ready is never high in the same cycle as out_valid; no bypass.
- Arithmetic: result {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(WORD_W*NUM_WORDS+1). Both operands are unsigned.
- Input-side rules:
  - Operand inputs are sampled only on the accept edge; in_a and in_b changes during RUN are ignored.
  - in_valid high while in_ready=0 has no effect; the requester must hold until accepted.
- idx never exceeds NUM_WORDS-1 and never wraps while in RUN.

Test Plan:
- Reset then idle, WORD_W=20, NUM_WORDS=4, in_valid=0 -> in_ready=1, out_valid=0, out_sum=0, out_cout=0, add_a=add_b=0.
- Full ripple: in_a=80'hFFFFF_FFFFF_FFFFF_FFFFF, in_b=0, in_cin=1, out_ready=1 -> add_cin sequence 1,1,1,1; out_valid exactly 4 edges after accept; out_sum=0, out_cout=1.
- Word boundary carry: in_a=80'h00000_00000_00000_FFFFF, in_b=80'h1, in_cin=0 -> out_sum=80'h00000_00000_00001_00000, out_cout=0; add_cin sequence 0,1,0,0.
- Backpressure: a=80'h12345_6789A_BCDEF_01234, b=80'h11111_11111_11111_11111, out_ready held 0 for 5 cycles after out_valid -> out_sum=80'h23456_789AB_CDF00_12345 held stable; in_ready=0 throughout; accept on the first out_ready=1 edge, then in_ready=1 next cycle.
- Back-to-back: in_valid held high with two queued operands -> second accept occurs exactly NUM_WORDS+2 cycles after the first; both results are correct against the reference model.
- Reset mid-RUN: assert rst_n=0 when idx=2 -> next cycle IDLE, out_valid never asserts for that operation, carry register=0; the following operation 1+1 yields out_sum=2.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Sequences a wide unsigned add through an external combinational WORD_W-bit adder,
// one word per cycle, least-significant word first, with a registered carry chain.
module wide_add_sequencer #(
    parameter int WORD_W    = 20,
    parameter int NUM_WORDS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] in_a,
    input  logic [WORD_W*NUM_WORDS-1:0] in_b,
    input  logic                        in_cin,
    output logic [WORD_W-1:0]           add_a,
    output logic [WORD_W-1:0]           add_b,
    output logic                        add_cin,
    input  logic [WORD_W-1:0]           add_sum,
    input  logic                        add_cout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_sum,
    output logic                        out_cout,
    output logic                        busy
);

    // state   | meaning
    // IDLE    | waiting for an operand pair, adder inputs held at zero
    // RUN     | feeding word r_idx to the adder, capturing sum and carry
    // DONE    | full result presented until the consumer takes it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int                TOT_W    = WORD_W * NUM_WORDS;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [TOT_W-1:0]   r_a;
    logic [TOT_W-1:0]   r_b;
    logic [WORD_W-1:0]  r_sum [NUM_WORDS];
    logic               r_cout;

    logic [WORD_W-1:0]  w_a_word [NUM_WORDS];
    logic [WORD_W-1:0]  w_b_word [NUM_WORDS];
    logic               w_accept;
    logic               w_last;

    // Word views of the operand registers and reassembly of the result words.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        assign w_a_word[g]                   = r_a[g*WORD_W +: WORD_W];
        assign w_b_word[g]                   = r_b[g*WORD_W +: WORD_W];
        assign out_sum[g*WORD_W +: WORD_W]   = r_sum[g];
    end

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_idx == LAST_IDX);
    assign out_cout = r_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        add_a        = '0;
        add_b        = '0;
        add_cin      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                add_a   = w_a_word[r_idx];
                add_b   = w_b_word[r_idx];
                add_cin = r_carry;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_cout  <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_sum[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_a     <= in_a;
                r_b     <= in_b;
                r_carry <= in_cin;
                r_idx   <= '0;
            end
            // Carry out of word idx becomes carry in of word idx+1.
            if (r_state == ST_RUN) begin
                r_sum[r_idx] <= add_sum;
                r_carry      <= add_cout;
                if (w_last) begin
                    r_cout <= add_cout;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: models the attached adder, runs table
// vectors, multi-cycle corner sequences and random operands against plain arithmetic.
module tb_wide_add_sequencer;

    localparam int WORD_W    = 20;
    localparam int NUM_WORDS = 4;
    localparam int TOT_W     = WORD_W * NUM_WORDS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [TOT_W-1:0]  in_a = '0;
    logic [TOT_W-1:0]  in_b = '0;
    logic              in_cin = 1'b0;
    logic [WORD_W-1:0] add_a;
    logic [WORD_W-1:0] add_b;
    logic              add_cin;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [TOT_W-1:0]  out_sum;
    logic              out_cout;
    logic              busy;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [TOT_W-1:0] a;
        logic [TOT_W-1:0] b;
        logic             cin;
        logic [TOT_W-1:0] sum;
        logic             cout;
        logic [3:0]       cin_seq;
        int               bp;
    } vec_t;

    vec_t vecs[5];

    wide_add_sequencer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // Attached combinational prefix adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WORD_W{1'b0}}, add_cin};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [TOT_W:0] model_add(input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b,
                                                 input logic cin);
        return {1'b0, a} + {1'b0, b} + (TOT_W+1)'(cin);
    endfunction

    // Carry into word k is the carry out of adding the low k words of both operands.
    function automatic logic [3:0] model_seq(input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b,
                                             input logic cin);
        logic [3:0]     seq;
        logic [TOT_W:0] mask;
        logic [TOT_W:0] t;
        seq = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            mask = ((TOT_W+1)'(1) << (WORD_W * k)) - (TOT_W+1)'(1);
            t    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (TOT_W+1)'(cin);
            t    = t >> (WORD_W * k);
            seq  = {t[0], seq[3:1]};
        end
        return seq;
    endfunction

    function automatic logic [WORD_W-1:0] rword();
        logic [WORD_W-1:0] w;
        case ($urandom_range(0, 3))
            0:       w = '0;
            1:       w = '1;
            default: w = WORD_W'($urandom);
        endcase
        return w;
    endfunction

    function automatic logic [TOT_W-1:0] roperand();
        logic [TOT_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            v = {rword(), v[TOT_W-1:WORD_W]};
        end
        return v;
    endfunction

    // One full transaction; returns result, carry-in sequence seen by the adder and latency.
    task automatic run_op(input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b, input logic cin,
                          input int bp, output logic [TOT_W-1:0] s, output logic c,
                          output logic [3:0] seq, output int lat);
        int w;
        s   = '0;
        c   = 1'b0;
        seq = '0;
        lat = 0;
        w   = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 128'(in_ready), 128'(1));
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_cin   = ~cin;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            if (lat < NUM_WORDS) begin
                seq = {add_cin, seq[3:1]};
                check("run_add_a", 128'(add_a), 128'(WORD_W'(a >> (lat * WORD_W))));
                check("run_add_b", 128'(add_b), 128'(WORD_W'(b >> (lat * WORD_W))));
                check("run_in_ready", 128'(in_ready), 128'(0));
            end
            @(posedge clk);
            lat++;
        end
        check("latency", 128'(lat), 128'(NUM_WORDS));
        s = out_sum;
        c = out_cout;
        for (int k = 0; k < bp; k++) begin
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_sum_stable", 128'(out_sum), 128'(s));
            check("bp_cout_stable", 128'(out_cout), 128'(c));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_in_ready", 128'(in_ready), 128'(1));
        check("post_valid", 128'(out_valid), 128'(0));
        check("post_sum_kept", 128'(out_sum), 128'(s));
    endtask

    initial begin
        logic [TOT_W-1:0] s;
        logic             c;
        logic [3:0]       seq;
        int               lat;
        logic [TOT_W:0]   m;
        logic [TOT_W-1:0] ra;
        logic [TOT_W-1:0] rb;
        logic             rc;
        logic [TOT_W-1:0] op_a [2];
        logic [TOT_W-1:0] op_b [2];
        logic             op_c [2];
        logic [TOT_W-1:0] res_s [2];
        logic             res_c [2];
        int               acc_cyc [2];
        int               n_acc;
        int               n_res;
        logic             acc_now;

        vecs[0] = '{a: 80'hFFFFF_FFFFF_FFFFF_FFFFF, b: 80'h0, cin: 1'b1,
                    sum: 80'h0, cout: 1'b1, cin_seq: 4'b1111, bp: 0};
        vecs[1] = '{a: 80'h00000_00000_00000_FFFFF, b: 80'h1, cin: 1'b0,
                    sum: 80'h00000_00000_00001_00000, cout: 1'b0, cin_seq: 4'b0010, bp: 0};
        vecs[2] = '{a: 80'h12345_6789A_BCDEF_01234, b: 80'h11111_11111_11111_11111, cin: 1'b0,
                    sum: 80'h23456_789AB_CDF00_12345, cout: 1'b0, cin_seq: 4'b0000, bp: 5};
        vecs[3] = '{a: 80'hFFFFF_FFFFF_FFFFF_FFFFF, b: 80'hFFFFF_FFFFF_FFFFF_FFFFF, cin: 1'b1,
                    sum: 80'hFFFFF_FFFFF_FFFFF_FFFFF, cout: 1'b1, cin_seq: 4'b1111, bp: 1};
        vecs[4] = '{a: 80'h80000_00000_00000_00000, b: 80'h80000_00000_00000_00000, cin: 1'b0,
                    sum: 80'h0, cout: 1'b1, cin_seq: 4'b0000, bp: 2};

        // Reset and idle state.
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_sum", 128'(out_sum), 128'(0));
        check("rst_out_cout", 128'(out_cout), 128'(0));
        check("rst_add_a", 128'(add_a), 128'(0));
        check("rst_add_b", 128'(add_b), 128'(0));
        check("rst_add_cin", 128'(add_cin), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].bp, s, c, seq, lat);
            check("vec_sum", 128'(s), 128'(vecs[i].sum));
            check("vec_cout", 128'(c), 128'(vecs[i].cout));
            check("vec_cin_seq", 128'(seq), 128'(vecs[i].cin_seq));
        end

        // Back-to-back: in_valid held high across two operands.
        op_a[0] = roperand();
        op_b[0] = roperand();
        op_c[0] = 1'($urandom_range(0, 1));
        op_a[1] = roperand();
        op_b[1] = roperand();
        op_c[1] = 1'($urandom_range(0, 1));
        n_acc   = 0;
        n_res   = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_a      = op_a[0];
        in_b      = op_b[0];
        in_cin    = op_c[0];
        in_valid  = 1'b1;
        for (int cy = 0; cy < 40 && n_res < 2; cy++) begin
            check("ready_and_valid", 128'(in_ready & out_valid), 128'(0));
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready && n_res < 2) begin
                res_s[n_res] = out_sum;
                res_c[n_res] = out_cout;
                n_res++;
            end
            @(posedge clk);
            #1;
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = cy;
                n_acc++;
                if (n_acc == 1) begin
                    in_a   = op_a[1];
                    in_b   = op_b[1];
                    in_cin = op_c[1];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accepts", 128'(n_acc), 128'(2));
        check("b2b_results", 128'(n_res), 128'(2));
        if (n_acc == 2) begin
            check("b2b_interval", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NUM_WORDS + 2));
        end
        for (int i = 0; i < n_res; i++) begin
            m = model_add(op_a[i], op_b[i], op_c[i]);
            check("b2b_sum", 128'(res_s[i]), 128'(m[TOT_W-1:0]));
            check("b2b_cout", 128'(res_c[i]), 128'(m[TOT_W]));
        end

        // Reset in the middle of RUN, while word 2 is on the adder.
        @(negedge clk);
        in_a     = 80'hFFFFF_FFFFF_FFFFF_FFFFF;
        in_b     = 80'h1;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_idx2_add_a", 128'(add_a), 128'(20'hFFFFF));
        check("mid_idx2_add_cin", 128'(add_cin), 128'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 128'(in_ready), 128'(1));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_sum", 128'(out_sum), 128'(0));
        for (int k = 0; k < 6; k++) begin
            check("mid_rst_no_valid", 128'(out_valid), 128'(0));
            @(negedge clk);
        end
        run_op(80'h1, 80'h1, 1'b0, 0, s, c, seq, lat);
        check("after_rst_sum", 128'(s), 128'(2));
        check("after_rst_cout", 128'(c), 128'(0));
        check("after_rst_seq", 128'(seq), 128'(0));

        // Random operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ra = roperand();
            rb = roperand();
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, int'($urandom_range(0, 2)), s, c, seq, lat);
            m = model_add(ra, rb, rc);
            check("rand_sum", 128'(s), 128'(m[TOT_W-1:0]));
            check("rand_cout", 128'(c), 128'(m[TOT_W]));
            check("rand_cin_seq", 128'(seq), 128'(model_seq(ra, rb, rc)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
